bus_initiator: RTL and testbench

// Bus initiator: the requesting end of the bus_* target interface (trans/addr/write/wdata -> ready/resp/rdata).

---
 rtl/bus_initiator.sv | 145 ++++++++++++++
 tb/tb_bus_initiator.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_initiator.sv
// ============================================================================
// Module  : bus_initiator
// Brief   : Single-transfer bus initiator with request/response channels and
//           a transfer watchdog.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_initiator #(
    parameter int unsigned timeout_p = 255,
    parameter int unsigned cntw_p    = 8
) (
    input  logic              main_clk_i,
    input  logic              main_rst_an_i,
    input  logic              req_valid_i,
    output logic              req_accept_o,
    input  logic [31:0]       req_addr_i,
    input  logic              req_write_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_accept_i,
    output logic              rsp_err_o,
    output logic [31:0]       rsp_rdata_o,
    output logic [1:0]        bus_trans_o,
    output logic [31:0]       bus_addr_o,
    output logic              bus_write_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_ready_i,
    input  logic              bus_resp_i,
    input  logic [31:0]       bus_rdata_i,
    output logic              busy_o,
    output logic              timeout_o,
    output logic [cntw_p-1:0] err_cnt_o
);

    localparam int unsigned        c_TMR_W        = (timeout_p > 0) ? $clog2(timeout_p + 1) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST     = c_TMR_W'(timeout_p - 1);
    localparam logic [1:0]         c_TRANS_IDLE   = 2'b00;
    localparam logic [1:0]         c_TRANS_SINGLE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_TMR_W-1:0]  r_timer;
    logic                r_req_accept;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic [31:0]         r_rsp_rdata;
    logic [1:0]          r_bus_trans;
    logic [31:0]         r_bus_addr;
    logic                r_bus_write;
    logic [31:0]         r_bus_wdata;
    logic                r_busy;
    logic                r_timeout;
    logic [cntw_p-1:0]   r_err_cnt;

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            r_state      <= ST_IDLE;
            r_timer      <= '0;
            r_req_accept <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_rdata  <= '0;
            r_bus_trans  <= c_TRANS_IDLE;
            r_bus_addr   <= '0;
            r_bus_write  <= 1'b0;
            r_bus_wdata  <= '0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_bus_addr   <= req_addr_i;
                        r_bus_write  <= req_write_i;
                        r_bus_wdata  <= req_wdata_i;
                        r_bus_trans  <= c_TRANS_SINGLE;
                        r_timer      <= '0;
                        r_req_accept <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // A completion in the last allowed cycle takes priority over the watchdog.
                    if (bus_ready_i) begin
                        r_rsp_err   <= bus_resp_i;
                        r_rsp_rdata <= (!r_bus_write && !bus_resp_i) ? bus_rdata_i : 32'h0;
                        r_bus_trans <= c_TRANS_IDLE;
                        r_rsp_valid <= 1'b1;
                        if (bus_resp_i && (r_err_cnt != '1)) begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                        end
                        r_state     <= ST_RSP;
                    end else if ((timeout_p != 0) && (r_timer == c_TMR_LAST)) begin
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= 32'h0;
                        r_timeout   <= 1'b1;
                        r_bus_trans <= c_TRANS_IDLE;
                        r_rsp_valid <= 1'b1;
                        if (r_err_cnt != '1) begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                        end
                        r_state     <= ST_RSP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_RSP: begin
                    if (rsp_accept_i) begin
                        r_rsp_valid  <= 1'b0;
                        r_req_accept <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_accept_o = r_req_accept;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_err_o    = r_rsp_err;
    assign rsp_rdata_o  = r_rsp_rdata;
    assign bus_trans_o  = r_bus_trans;
    assign bus_addr_o   = r_bus_addr;
    assign bus_write_o  = r_bus_write;
    assign bus_wdata_o  = r_bus_wdata;
    assign busy_o       = r_busy;
    assign timeout_o    = r_timeout;
    assign err_cnt_o    = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_bus_initiator.sv
// ============================================================================
// Module  : tb_bus_initiator
// Brief   : Directed and randomized transfers against a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_initiator;

    localparam int unsigned c_TMO = 4;
    localparam int unsigned c_CW  = 2;
    localparam int unsigned c_SAT = (1 << c_CW) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_accept;
    logic [31:0]       req_addr;
    logic              req_write;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_accept;
    logic              rsp_err;
    logic [31:0]       rsp_rdata;
    logic [1:0]        bus_trans;
    logic [31:0]       bus_addr;
    logic              bus_write;
    logic [31:0]       bus_wdata;
    logic              bus_ready;
    logic              bus_resp;
    logic [31:0]       bus_rdata;
    logic              busy;
    logic              timeout;
    logic [c_CW-1:0]   err_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    bus_initiator #(
        .timeout_p (c_TMO),
        .cntw_p    (c_CW)
    ) dut (
        .main_clk_i    (clk),
        .main_rst_an_i (rst_n),
        .req_valid_i   (req_valid),
        .req_accept_o  (req_accept),
        .req_addr_i    (req_addr),
        .req_write_i   (req_write),
        .req_wdata_i   (req_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_accept_i  (rsp_accept),
        .rsp_err_o     (rsp_err),
        .rsp_rdata_o   (rsp_rdata),
        .bus_trans_o   (bus_trans),
        .bus_addr_o    (bus_addr),
        .bus_write_o   (bus_write),
        .bus_wdata_o   (bus_wdata),
        .bus_ready_i   (bus_ready),
        .bus_resp_i    (bus_resp),
        .bus_rdata_i   (bus_rdata),
        .busy_o        (busy),
        .timeout_o     (timeout),
        .err_cnt_o     (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // wait_n: SINGLE cycles without ready before the target completes.
    task automatic xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                        input int wait_n, input logic resp, input logic [31:0] rd,
                        input int acc_delay, input logic hold_valid);
        bit          timed_out;
        int          exp_singles;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          singles;
        int          pulses;

        timed_out   = (c_TMO != 0) && (wait_n >= int'(c_TMO));
        exp_singles = timed_out ? int'(c_TMO) : wait_n + 1;
        exp_err     = timed_out ? 1'b1 : resp;
        exp_rd      = (exp_err || wr) ? 32'h0 : rd;
        if (exp_err && exp_cnt < int'(c_SAT)) exp_cnt++;

        chk("idle_accept", {31'b0, req_accept}, 32'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_write = wr;
        req_wdata = wd;
        bus_ready = 1'b0;
        tick;
        req_valid = hold_valid;
        req_addr  = $urandom;
        req_write = 1'($urandom);
        req_wdata = $urandom;

        singles = 0;
        pulses  = 0;
        while (bus_trans == 2'b10 && singles < 20) begin
            chk("bus_addr", bus_addr, a);
            chk("bus_write", {31'b0, bus_write}, {31'b0, wr});
            chk("bus_wdata", bus_wdata, wd);
            chk("accept_in_bus", {31'b0, req_accept}, 32'd0);
            bus_ready = (singles == wait_n);
            bus_resp  = (singles == wait_n) ? resp : 1'($urandom);
            bus_rdata = (singles == wait_n) ? rd : $urandom;
            tick;
            singles++;
            if (timeout) pulses++;
        end
        bus_ready = 1'b0;

        chk("single_cycles", singles, exp_singles);
        chk("timeout_pulses", pulses, {31'b0, timed_out});
        chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("err_cnt", {30'b0, err_cnt}, exp_cnt);
        chk("busy_rsp", {31'b0, busy}, 32'd1);

        rsp_accept = 1'b0;
        repeat (acc_delay) begin
            bus_ready = 1'($urandom);
            bus_resp  = 1'b1;
            bus_rdata = $urandom;
            tick;
            chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_err", {31'b0, rsp_err}, {31'b0, exp_err});
            chk("hold_rdata", rsp_rdata, exp_rd);
            chk("hold_accept", {31'b0, req_accept}, 32'd0);
            chk("hold_trans", {30'b0, bus_trans}, 32'd0);
            chk("hold_timeout", {31'b0, timeout}, 32'd0);
            chk("hold_err_cnt", {30'b0, err_cnt}, exp_cnt);
        end
        bus_ready  = 1'b0;
        rsp_accept = 1'b1;
        tick;
        rsp_accept = 1'b0;
        req_valid  = 1'b0;
        chk("post_valid", {31'b0, rsp_valid}, 32'd0);
        chk("post_accept", {31'b0, req_accept}, 32'd1);
        chk("post_busy", {31'b0, busy}, 32'd0);
        chk("post_timeout", {31'b0, timeout}, 32'd0);
        chk("post_trans", {30'b0, bus_trans}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_write  = 1'b0;
        req_wdata  = '0;
        rsp_accept = 1'b0;
        bus_ready  = 1'b0;
        bus_resp   = 1'b0;
        bus_rdata  = '0;
        repeat (3) tick;

        chk("rst_accept", {31'b0, req_accept}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_trans", {30'b0, bus_trans}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_err_cnt", {30'b0, err_cnt}, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        rst_n = 1'b1;
        tick;

        xfer(32'h0000_0010, 1'b1, 32'hCAFE_F00D, 0, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
        xfer(32'h0000_0020, 1'b0, 32'h0, 3, 1'b0, 32'h1234_5678, 1, 1'b0);
        xfer(32'h0000_0030, 1'b0, 32'h0, 1, 1'b1, 32'hFFFF_FFFF, 0, 1'b0);
        xfer(32'h0000_0040, 1'b0, 32'h0, 100, 1'b0, 32'h5555_AAAA, 0, 1'b0);
        xfer(32'h0000_0044, 1'b0, 32'h0, 3, 1'b0, 32'h0BAD_F00D, 0, 1'b0);
        xfer(32'h0000_0050, 1'b0, 32'h0, 2, 1'b0, 32'h7777_1111, 5, 1'b1);

        // Bus inputs outside a transfer must have no effect.
        bus_ready = 1'b1;
        bus_resp  = 1'b1;
        repeat (2) tick;
        bus_ready = 1'b0;
        chk("idle_ignore_valid", {31'b0, rsp_valid}, 32'd0);
        chk("idle_ignore_cnt", {30'b0, err_cnt}, exp_cnt);
        chk("idle_ignore_trans", {30'b0, bus_trans}, 32'd0);

        for (int i = 0; i < 24; i++) begin
            xfer($urandom, 1'($urandom), $urandom, int'($urandom_range(0, 6)),
                 1'($urandom), $urandom, int'($urandom_range(0, 3)), 1'($urandom));
        end

        for (int i = 0; i < 5; i++) begin
            xfer($urandom, 1'b0, $urandom, 0, 1'b1, $urandom, 0, 1'b0);
        end
        chk("err_cnt_saturated", {30'b0, err_cnt}, c_SAT);

        // Reset in the middle of a transfer drops it without a response.
        req_valid = 1'b1;
        req_addr  = 32'h0000_0060;
        req_write = 1'b0;
        tick;
        req_valid = 1'b0;
        tick;
        chk("pre_rst_trans", {30'b0, bus_trans}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        chk("async_rst_trans", {30'b0, bus_trans}, 32'd0);
        chk("async_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("async_rst_accept", {31'b0, req_accept}, 32'd1);
        chk("async_rst_busy", {31'b0, busy}, 32'd0);
        chk("async_rst_cnt", {30'b0, err_cnt}, 32'd0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("after_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("after_rst_trans", {30'b0, bus_trans}, 32'd0);

        xfer(32'h0000_0070, 1'b0, 32'h0, 1, 1'b0, 32'hA5A5_5A5A, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
